// File: rtl/cacheline_burst_pkg.sv
// cacheline_burst_pkg: shared state type and beat-count helper for the line/burst bridge
package cacheline_burst_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} cba_state_t;

    function automatic int beats(input int line_w, input int burst_w);
        return line_w / burst_w;
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: splits LLC lines into memory bursts and packs bursts back into lines
module cacheline_burst_adaptor
    import cacheline_burst_pkg::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic [ADDR_WIDTH-1:0]  wb_address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    output logic                   busy_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int BEATS  = beats(LINE_WIDTH, BURST_WIDTH);
    localparam int OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int CW     = $clog2(BEATS);
    localparam logic [ADDR_WIDTH-1:0] MASK = {{(ADDR_WIDTH-OFFSET){1'b1}}, {OFFSET{1'b0}}};

    if (LINE_WIDTH % BURST_WIDTH != 0 || BEATS < 2) begin : g_bad_params
        $error("cacheline_burst_adaptor: LINE_WIDTH must be a multiple of BURST_WIDTH with at least 2 beats");
    end

    cba_state_t                         state;
    logic [CW-1:0]                      cnt;
    logic [ADDR_WIDTH-1:0]              addr_q;
    logic [ADDR_WIDTH-1:0]              fill_addr;
    logic                               fill_pend;
    logic [BEATS-1:0][BURST_WIDTH-1:0]  buf_q;
    logic                               last;

    assign last      = cnt == CW'(BEATS - 1);
    assign line_o    = buf_q;
    assign address_o = addr_q;
    assign resp_o    = state == DONE;
    assign busy_o    = state != IDLE;
    assign read_o    = state == READ;
    assign write_o   = state == WRITE;
    assign burst_o   = (state == WRITE) ? buf_q[cnt] : '0;

    // Request capture, beat sequencing and line buffer updates
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            fill_addr <= '0;
            fill_pend <= 1'b0;
            buf_q     <= '0;
        end else begin
            case (state)
                IDLE: if (read_i || write_i) begin
                    addr_q    <= (read_i && write_i ? wb_address_i : address_i) & MASK;
                    fill_addr <= address_i & MASK;
                    fill_pend <= read_i && write_i;
                    buf_q     <= write_i ? line_i : buf_q;
                    state     <= write_i ? WRITE : READ;
                end
                WRITE: if (resp_i) begin
                    cnt    <= last ? '0 : cnt + 1'b1;
                    state  <= !last ? WRITE : fill_pend ? READ : DONE;
                    addr_q <= (last && fill_pend) ? fill_addr : addr_q;
                end
                READ: if (resp_i) begin
                    buf_q[cnt] <= burst_i;
                    cnt        <= last ? '0 : cnt + 1'b1;
                    state      <= last ? DONE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
